instruction_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of decode/control. Generates sequential word addresses for the synchronous instruction memory and buffers returned words in a small prefetch FIFO. Hands instructions to decode over a valid/ready handshake, and flushes and restarts fetch on a redirect (branch/jump) from the execute side.

---
 rtl/instruction_fetch_unit_if.sv | 23 ++
 rtl/instruction_fetch_unit.sv | 111 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/response, execute-side
// redirect, and the decode-facing valid/ready instruction handshake.
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: sequential word fetch from a 1-cycle synchronous imem into a
// small {pc, word} prefetch FIFO, with flush/restart on execute-side redirect.
module instruction_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  instruction_fetch_unit_if.master  bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  entry_t          fifo_d [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  logic            kill_q, kill_d;

  logic            issue_c;
  logic            push_c;
  logic            pop_c;
  logic [31:0]     redirect_pc_c;

  // Space check uses registered occupancy only, so a same-cycle pop never frees a slot.
  assign issue_c       = !rst && !bus.redirect &&
                         ((count_q + CW'(inflight_q)) < CW'(DEPTH));
  assign push_c        = inflight_q && !kill_q && !bus.redirect;
  assign pop_c         = (count_q != '0) && bus.inst_ready;
  assign redirect_pc_c = bus.redirect_pc & ~32'h0000_0003;

  always_comb begin
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue_c;
    kill_d        = bus.redirect;

    if (issue_c) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_pc_d = fetch_pc_q;
    end

    if (push_c) begin
      fifo_d[wr_ptr_q] = '{pc: inflight_pc_q, word: bus.imem_rdata};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Redirect discards everything buffered and restarts at the aligned target.
    if (bus.redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      fifo_q        <= fifo_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  assign bus.imem_req   = issue_c;
  assign bus.imem_addr  = rst ? RESET_PC : fetch_pc_q;
  assign bus.inst_valid = !rst && (count_q != '0);
  assign bus.inst       = rst ? 32'h0 : fifo_q[rd_ptr_q].word;
  assign bus.inst_pc    = rst ? 32'h0 : fifo_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; imem model returns addr>>2 as the word.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   n_vec = 0;
  int   n_err = 0;

  instruction_fetch_unit_if ifc ();
  instruction_fetch_unit_if ifc2 ();

  instruction_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  instruction_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk (clk),
    .rst (rst2),
    .bus (ifc2.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ifc.imem_rdata  <= ifc.imem_req  ? (ifc.imem_addr  >> 2) : 32'hBADC_0DE0;
    ifc2.imem_rdata <= ifc2.imem_req ? (ifc2.imem_addr >> 2) : 32'hBADC_0DE0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.redirect = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [64:0] exp;
    rst = 1'b1;
    ifc.inst_ready = 1'b1;
    #1;
    n_vec++;
    if ({ifc.imem_req, ifc.inst_valid, ifc.inst, ifc.inst_pc, ifc.imem_addr} !== {2'b00, 96'h0}) begin
      n_err++;
      $display("FAIL reset_outputs got req=%b valid=%b inst=%h pc=%h addr=%h exp all zero",
               ifc.imem_req, ifc.inst_valid, ifc.inst, ifc.inst_pc, ifc.imem_addr);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_vec++;
      if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 32'(4 * k)}) begin
        n_err++;
        $display("FAIL stream_req k=%0d got req=%b addr=%h exp req=1 addr=%h",
                 k, ifc.imem_req, ifc.imem_addr, 32'(4 * k));
      end
      exp = (k >= 2) ? {1'b1, 32'(k - 2), 32'(4 * (k - 2))} : {1'b0, ifc.inst, ifc.inst_pc};
      n_vec++;
      if ({ifc.inst_valid, ifc.inst, ifc.inst_pc} !== exp) begin
        n_err++;
        $display("FAIL stream_inst k=%0d got v=%b inst=%h pc=%h exp v=%b inst=%h pc=%h",
                 k, ifc.inst_valid, ifc.inst, ifc.inst_pc, exp[64], exp[63:32], exp[31:0]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    logic [64:0] exp;
    nreq = 0;
    ifc.inst_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      #1;
      if (ifc.imem_req) nreq++;
      n_vec++;
      if (ifc.imem_req !== (k < 4)) begin
        n_err++;
        $display("FAIL bp_req k=%0d got %b exp %b", k, ifc.imem_req, (k < 4));
      end
      if (k >= 2) begin
        n_vec++;
        if ({ifc.inst_valid, ifc.inst, ifc.inst_pc} !== {1'b1, 64'h0}) begin
          n_err++;
          $display("FAIL bp_hold k=%0d got v=%b inst=%h pc=%h exp v=1 inst=0 pc=0",
                   k, ifc.inst_valid, ifc.inst, ifc.inst_pc);
        end
      end
      step();
    end
    n_vec++;
    if (nreq != 4) begin
      n_err++;
      $display("FAIL bp_req_count got %0d exp 4", nreq);
    end
    ifc.inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp = {1'b1, 32'(k), 32'(4 * k)};
      n_vec++;
      if ({ifc.inst_valid, ifc.inst, ifc.inst_pc} !== exp) begin
        n_err++;
        $display("FAIL bp_drain k=%0d got v=%b inst=%h pc=%h exp inst=%h pc=%h",
                 k, ifc.inst_valid, ifc.inst, ifc.inst_pc, exp[63:32], exp[31:0]);
      end
      step();
    end
  endtask

  task automatic test_redirect();
    ifc.inst_ready = 1'b0;
    do_reset();
    repeat (4) step();
    ifc.redirect = 1'b1;
    ifc.redirect_pc = 32'h0000_0103;
    #1;
    n_vec++;
    if ({ifc.imem_req, ifc.inst_valid, ifc.inst_pc} !== {2'b01, 32'h0}) begin
      n_err++;
      $display("FAIL redir_cycle got req=%b v=%b pc=%h exp req=0 v=1 pc=0",
               ifc.imem_req, ifc.inst_valid, ifc.inst_pc);
    end
    step();
    ifc.redirect = 1'b0;
    ifc.inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k < 2) begin
        n_vec++;
        if ({ifc.imem_req, ifc.imem_addr, ifc.inst_valid} !== {1'b1, 32'h100 + 32'(4 * k), 1'b0}) begin
          n_err++;
          $display("FAIL redir_refetch k=%0d got req=%b addr=%h v=%b exp req=1 addr=%h v=0",
                   k, ifc.imem_req, ifc.imem_addr, ifc.inst_valid, 32'h100 + 32'(4 * k));
        end
      end else begin
        n_vec++;
        if ({ifc.inst_valid, ifc.inst, ifc.inst_pc} !== {1'b1, 32'h3E + 32'(k), 32'h0F8 + 32'(4 * k)}) begin
          n_err++;
          $display("FAIL redir_inst k=%0d got v=%b inst=%h pc=%h exp inst=%h pc=%h",
                   k, ifc.inst_valid, ifc.inst, ifc.inst_pc, 32'h3E + 32'(k), 32'h0F8 + 32'(4 * k));
        end
      end
      step();
    end
  endtask

  task automatic test_redirect_pop();
    ifc.inst_ready = 1'b1;
    do_reset();
    repeat (5) step();
    ifc.redirect = 1'b1;
    ifc.redirect_pc = 32'h0000_0200;
    #1;
    n_vec++;
    if ({ifc.imem_req, ifc.inst_valid, ifc.inst, ifc.inst_pc} !== {2'b01, 32'h3, 32'hC}) begin
      n_err++;
      $display("FAIL rpop_cycle got req=%b v=%b inst=%h pc=%h exp req=0 v=1 inst=3 pc=c",
               ifc.imem_req, ifc.inst_valid, ifc.inst, ifc.inst_pc);
    end
    step();
    ifc.redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k < 2) begin
        n_vec++;
        if ({ifc.imem_req, ifc.imem_addr, ifc.inst_valid} !== {1'b1, 32'h200 + 32'(4 * k), 1'b0}) begin
          n_err++;
          $display("FAIL rpop_refetch k=%0d got req=%b addr=%h v=%b exp addr=%h v=0",
                   k, ifc.imem_req, ifc.imem_addr, ifc.inst_valid, 32'h200 + 32'(4 * k));
        end
      end else begin
        n_vec++;
        if ({ifc.inst_valid, ifc.inst, ifc.inst_pc} !== {1'b1, 32'h7E + 32'(k), 32'h1F8 + 32'(4 * k)}) begin
          n_err++;
          $display("FAIL rpop_inst k=%0d got v=%b inst=%h pc=%h exp inst=%h pc=%h",
                   k, ifc.inst_valid, ifc.inst, ifc.inst_pc, 32'h7E + 32'(k), 32'h1F8 + 32'(4 * k));
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    ifc.inst_ready = 1'b1;
    do_reset();
    repeat (5) step();
    ifc.redirect = 1'b1;
    ifc.redirect_pc = 32'h0000_0200;
    step();
    ifc.redirect_pc = 32'h0000_030A;
    #1;
    n_vec++;
    if ({ifc.imem_req, ifc.inst_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_second got req=%b v=%b exp req=0 v=0", ifc.imem_req, ifc.inst_valid);
    end
    step();
    ifc.redirect = 1'b0;
    #1;
    n_vec++;
    if ({ifc.imem_req, ifc.imem_addr, ifc.inst_valid} !== {1'b1, 32'h308, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_refetch got req=%b addr=%h v=%b exp req=1 addr=308 v=0",
               ifc.imem_req, ifc.imem_addr, ifc.inst_valid);
    end
    step();
    step();
    n_vec++;
    if ({ifc.inst_valid, ifc.inst, ifc.inst_pc} !== {1'b1, 32'hC2, 32'h308}) begin
      n_err++;
      $display("FAIL b2b_inst got v=%b inst=%h pc=%h exp v=1 inst=c2 pc=308",
               ifc.inst_valid, ifc.inst, ifc.inst_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'hFFFF_FFF8;
    exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000;
    exp_addr[3] = 32'h0000_0004;
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++;
      if ({ifc2.imem_req, ifc2.imem_addr} !== {1'b1, exp_addr[k]}) begin
        n_err++;
        $display("FAIL wrap_addr k=%0d got req=%b addr=%h exp req=1 addr=%h",
                 k, ifc2.imem_req, ifc2.imem_addr, exp_addr[k]);
      end
      if (k >= 2) begin
        n_vec++;
        if ({ifc2.inst_valid, ifc2.inst, ifc2.inst_pc} !== {1'b1, exp_addr[k-2] >> 2, exp_addr[k-2]}) begin
          n_err++;
          $display("FAIL wrap_inst k=%0d got v=%b inst=%h pc=%h exp pc=%h",
                   k, ifc2.inst_valid, ifc2.inst, ifc2.inst_pc, exp_addr[k-2]);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    ifc.inst_ready = 1'b0;
    do_reset();
    repeat (4) step();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++;
      if ({ifc.imem_req, ifc.inst_valid, ifc.inst, ifc.inst_pc, ifc.imem_addr} !== {2'b00, 96'h0}) begin
        n_err++;
        $display("FAIL rmid_hold k=%0d got req=%b v=%b inst=%h pc=%h addr=%h exp all zero",
                 k, ifc.imem_req, ifc.inst_valid, ifc.inst, ifc.inst_pc, ifc.imem_addr);
      end
      step();
    end
    rst = 1'b0;
    ifc.inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k < 2) begin
        n_vec++;
        if ({ifc.imem_req, ifc.imem_addr, ifc.inst_valid} !== {1'b1, 32'(4 * k), 1'b0}) begin
          n_err++;
          $display("FAIL rmid_restart k=%0d got req=%b addr=%h v=%b exp addr=%h v=0",
                   k, ifc.imem_req, ifc.imem_addr, ifc.inst_valid, 32'(4 * k));
        end
      end else begin
        n_vec++;
        if ({ifc.inst_valid, ifc.inst, ifc.inst_pc} !== {1'b1, 32'(k - 2), 32'(4 * (k - 2))}) begin
          n_err++;
          $display("FAIL rmid_inst k=%0d got v=%b inst=%h pc=%h exp pc=%h",
                   k, ifc.inst_valid, ifc.inst, ifc.inst_pc, 32'(4 * (k - 2)));
        end
      end
      step();
    end
  endtask

  initial begin
    rst              = 1'b1;
    rst2             = 1'b1;
    ifc.redirect     = 1'b0;
    ifc.redirect_pc  = 32'h0;
    ifc.inst_ready   = 1'b1;
    ifc2.redirect    = 1'b0;
    ifc2.redirect_pc = 32'h0;
    ifc2.inst_ready  = 1'b1;
    step();
    test_reset();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
